// File: rtl/anim_pkg.sv
// Shared types and sizing helpers for the frame-synchronous animation blocks.
package anim_pkg;

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } sway_state_t;

  localparam int SCROLL_W = 10;

  // Width of the dwell counter; never narrower than one bit so DWELL=0 still elaborates.
  function automatic int dwell_cnt_w(input int dwell);
    int w;
    w = $clog2(dwell + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/grass_sway_animator_if.sv
// Bundles the frame input, pause control and motion outputs of grass_sway_animator.
interface grass_sway_animator_if #(
  parameter int SWAY_W = 6
);
  import anim_pkg::*;

  // No valid/ready handshake: frame_tick is a one-cycle pulse, and scroll/sway/sway_dir
  // change only on the cycle frame_tick rises and are stable for the rest of the frame.
  logic                vsync_in;
  logic                pause;
  logic                frame_tick;
  logic [SCROLL_W-1:0] scroll;
  logic [SWAY_W-1:0]   sway;
  logic                sway_dir;
  sway_state_t         dbg_state;

  modport slave (
    input  vsync_in,
    input  pause,
    output frame_tick,
    output scroll,
    output sway,
    output sway_dir,
    output dbg_state
  );

  modport master (
    output vsync_in,
    output pause,
    input  frame_tick,
    input  scroll,
    input  sway,
    input  sway_dir,
    input  dbg_state
  );

endinterface

// File: rtl/vsync_edge_detect.sv
// Rising-edge detector for a same-domain sync strobe; the history register presets
// high on reset so a sync line already high after reset does not produce an event.
module vsync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b1;
    end else begin
      r_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_q;

endmodule

// File: rtl/grass_sway_animator.sv
// Frame-synchronous motion sequencer: wrapping scroll offset plus a ping-pong sway
// with dwell at each extreme, all advanced from vsync rising edges in the clk domain.
module grass_sway_animator
  import anim_pkg::*;
#(
  parameter int SWAY_W      = 6,
  parameter int SWAY_MIN    = 1,
  parameter int SWAY_MAX    = 32,
  parameter int DWELL       = 2,
  parameter int FRAME_DIV   = 1,
  parameter int SCROLL_STEP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  grass_sway_animator_if.slave bus
);

  localparam int CMP_W = SWAY_W + 1;
  localparam int DCW   = dwell_cnt_w(DWELL);
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [CMP_W-1:0]    MAX_C      = CMP_W'(SWAY_MAX);
  localparam logic [CMP_W-1:0]    MIN_P1_C   = CMP_W'(SWAY_MIN + 1);
  localparam logic [SWAY_W-1:0]   MIN_S      = SWAY_W'(SWAY_MIN);
  localparam logic [SWAY_W-1:0]   MAX_S      = SWAY_W'(SWAY_MAX);
  localparam logic [DCW-1:0]      DWELL_LAST = DCW'((DWELL > 0) ? DWELL - 1 : 0);
  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(FRAME_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_INC = SCROLL_W'(SCROLL_STEP);

  logic w_rise;
  logic w_adv;
  logic w_step;

  logic                r_tick;
  logic [SCROLL_W-1:0] r_scroll;
  logic [SWAY_W-1:0]   r_sway;
  sway_state_t         r_state;
  logic                r_sway_dir;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [DCW-1:0]      r_dwell_cnt;

  sway_state_t         w_state_nx;
  logic [SWAY_W-1:0]   w_sway_nx;
  logic [DCW-1:0]      w_dwell_nx;
  logic                w_dir_nx;
  logic [CMP_W-1:0]    w_sway_ext;
  logic [CMP_W-1:0]    w_sway_inc;

  vsync_edge_detect u_vsync_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (bus.vsync_in),
    .o_rise (w_rise)
  );

  assign w_adv  = w_rise & ~bus.pause;
  assign w_step = w_adv & (r_div_cnt == DIV_LAST);

  // Limit compares run one bit wider than sway so SWAY_MAX near 2**SWAY_W-1 cannot wrap.
  assign w_sway_ext = {1'b0, r_sway};
  assign w_sway_inc = w_sway_ext + 1'b1;

  // Candidate next values assuming an advance step; applied only when w_step is set.
  // sway_dir reports the phase that produced the new sway value, i.e. the pre-step state.
  always_comb begin
    w_state_nx = r_state;
    w_sway_nx  = r_sway;
    w_dwell_nx = r_dwell_cnt;
    w_dir_nx   = (r_state == RISE) || (r_state == HOLD_HI);
    case (r_state)
      RISE: begin
        if (w_sway_inc >= MAX_C) begin
          w_sway_nx  = MAX_S;
          w_dwell_nx = '0;
          if (DWELL == 0) begin
            w_state_nx = FALL;
          end else begin
            w_state_nx = HOLD_HI;
          end
        end else begin
          w_sway_nx = w_sway_inc[SWAY_W-1:0];
        end
      end
      HOLD_HI: begin
        if (r_dwell_cnt == DWELL_LAST) begin
          w_state_nx = FALL;
        end else begin
          w_dwell_nx = r_dwell_cnt + 1'b1;
        end
      end
      FALL: begin
        if (w_sway_ext <= MIN_P1_C) begin
          w_sway_nx  = MIN_S;
          w_dwell_nx = '0;
          if (DWELL == 0) begin
            w_state_nx = RISE;
          end else begin
            w_state_nx = HOLD_LO;
          end
        end else begin
          w_sway_nx = r_sway - 1'b1;
        end
      end
      HOLD_LO: begin
        if (r_dwell_cnt == DWELL_LAST) begin
          w_state_nx = RISE;
        end else begin
          w_dwell_nx = r_dwell_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = RISE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick      <= 1'b0;
      r_scroll    <= '0;
      r_sway      <= MIN_S;
      r_state     <= RISE;
      r_sway_dir  <= 1'b1;
      r_div_cnt   <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_tick <= w_rise;
      if (w_adv) begin
        r_scroll <= r_scroll + SCROLL_INC;
        if (r_div_cnt == DIV_LAST) begin
          r_div_cnt <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end
      if (w_step) begin
        r_state     <= w_state_nx;
        r_sway      <= w_sway_nx;
        r_dwell_cnt <= w_dwell_nx;
        r_sway_dir  <= w_dir_nx;
      end
    end
  end

  assign bus.frame_tick = r_tick;
  assign bus.scroll     = r_scroll;
  assign bus.sway       = r_sway;
  assign bus.sway_dir   = r_sway_dir;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_grass_sway_animator.sv
// Bench for grass_sway_animator: four parameterisations share one vsync/pause/reset
// stream and are compared against a closed-form triangle-wave model of the sway.
module tb_grass_sway_animator;
  import anim_pkg::*;

  localparam int NI = 4;
  localparam int P_MIN   [NI] = '{1, 1, 1, 60};
  localparam int P_MAX   [NI] = '{4, 4, 4, 63};
  localparam int P_DWELL [NI] = '{2, 2, 3, 0};
  localparam int P_DIV   [NI] = '{1, 3, 1, 1};
  localparam int P_STEP  [NI] = '{1, 1, 1, 3};

  logic clk;
  logic reset;
  logic vsync;
  logic pause;

  logic        obs_tick   [NI];
  logic [9:0]  obs_scroll [NI];
  logic [5:0]  obs_sway   [NI];
  logic        obs_dir    [NI];
  sway_state_t obs_state  [NI];

  int checks;
  int failures;
  int n_adv      [NI];
  int tick_cnt   [NI];
  bit tick_first [NI];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    grass_sway_animator_if #(.SWAY_W(6)) u_if ();
    assign u_if.vsync_in = vsync;
    assign u_if.pause    = pause;
    grass_sway_animator #(
      .SWAY_W      (6),
      .SWAY_MIN    (P_MIN[g]),
      .SWAY_MAX    (P_MAX[g]),
      .DWELL       (P_DWELL[g]),
      .FRAME_DIV   (P_DIV[g]),
      .SCROLL_STEP (P_STEP[g])
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
    );
    assign obs_tick[g]   = u_if.frame_tick;
    assign obs_scroll[g] = u_if.scroll;
    assign obs_sway[g]   = u_if.sway;
    assign obs_dir[g]    = u_if.sway_dir;
    assign obs_state[g]  = u_if.dbg_state;
  end

  // ---------------- reference model ----------------
  // After k advance steps the sway is a triangle wave of period 2R+2D, R = MAX-MIN.
  function automatic int k_of(input int i);
    return n_adv[i] / P_DIV[i];
  endfunction

  function automatic int exp_sway(input int i);
    int r, d, p;
    r = P_MAX[i] - P_MIN[i];
    d = P_DWELL[i];
    p = k_of(i) % (2 * r + 2 * d);
    if (p <= r) return P_MIN[i] + p;
    if (p <= r + d) return P_MAX[i];
    if (p <= 2 * r + d) return P_MAX[i] - (p - r - d);
    return P_MIN[i];
  endfunction

  function automatic sway_state_t exp_state(input int i);
    int r, d, p;
    r = P_MAX[i] - P_MIN[i];
    d = P_DWELL[i];
    p = k_of(i) % (2 * r + 2 * d);
    if (p < r) return RISE;
    if (p < r + d) return HOLD_HI;
    if (p < 2 * r + d) return FALL;
    return HOLD_LO;
  endfunction

  function automatic bit exp_dir(input int i);
    int r, d, k;
    r = P_MAX[i] - P_MIN[i];
    d = P_DWELL[i];
    k = k_of(i);
    if (k == 0) return 1'b1;
    return ((k - 1) % (2 * r + 2 * d)) < (r + d);
  endfunction

  function automatic int exp_scroll(input int i);
    return (n_adv[i] * P_STEP[i]) % 1024;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    vsync = 1'b0;
    pause = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NI; i++) n_adv[i] = 0;
    @(negedge clk);
  endtask

  // One frame: vsync high for hi_len cycles then low for lo_len cycles (both >= 1).
  task automatic drive_frame(input bit p, input int hi_len, input int lo_len);
    for (int i = 0; i < NI; i++) begin
      tick_cnt[i]   = 0;
      tick_first[i] = 1'b0;
    end
    pause = p;
    vsync = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      tick_first[i] = (obs_tick[i] === 1'b1);
      tick_cnt[i]  += (obs_tick[i] === 1'b1) ? 1 : 0;
    end
    for (int c = 1; c < hi_len + lo_len; c++) begin
      if (c == hi_len) vsync = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) tick_cnt[i] += (obs_tick[i] === 1'b1) ? 1 : 0;
    end
    if (!p) begin
      for (int i = 0; i < NI; i++) n_adv[i]++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int seen;
    vsync = 1'b1;
    pause = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NI; i++) n_adv[i] = 0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) seen += (obs_tick[i] !== 1'b0) ? 1 : 0;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_no_tick: got %0d tick samples, want 0", seen);
    end
    for (int i = 0; i < NI; i++) begin
      checks += 4;
      if (obs_scroll[i] !== 10'd0) begin
        failures++;
        $display("FAIL reset_scroll inst=%0d got=%0d want=0", i, obs_scroll[i]);
      end
      if (obs_sway[i] !== 6'(P_MIN[i])) begin
        failures++;
        $display("FAIL reset_sway inst=%0d got=%0d want=%0d", i, obs_sway[i], P_MIN[i]);
      end
      if (obs_dir[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_dir inst=%0d got=%b want=1", i, obs_dir[i]);
      end
      if (obs_state[i] !== RISE) begin
        failures++;
        $display("FAIL reset_state inst=%0d got=%0d want=%0d", i, obs_state[i], RISE);
      end
    end
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sway_sequence();
    int sway_tab [11] = '{2, 3, 4, 4, 4, 3, 2, 1, 1, 1, 2};
    bit dir_tab  [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    apply_reset();
    for (int f = 0; f < 11; f++) begin
      drive_frame(1'b0, $urandom_range(1, 4), $urandom_range(1, 4));
      checks += 5;
      if (tick_cnt[0] != 1 || !tick_first[0]) begin
        failures++;
        $display("FAIL seq_tick frame=%0d got cnt=%0d first=%0d want cnt=1 first=1",
                 f, tick_cnt[0], tick_first[0]);
      end
      if (obs_sway[0] !== 6'(sway_tab[f])) begin
        failures++;
        $display("FAIL seq_sway frame=%0d got=%0d want=%0d", f, obs_sway[0], sway_tab[f]);
      end
      if (obs_dir[0] !== dir_tab[f]) begin
        failures++;
        $display("FAIL seq_dir frame=%0d got=%b want=%b", f, obs_dir[0], dir_tab[f]);
      end
      if (obs_sway[3] !== 6'(exp_sway(3))) begin
        failures++;
        $display("FAIL seq_sway_hi frame=%0d got=%0d want=%0d", f, obs_sway[3], exp_sway(3));
      end
      if (obs_state[3] !== exp_state(3)) begin
        failures++;
        $display("FAIL seq_state_hi frame=%0d got=%0d want=%0d", f, obs_state[3], exp_state(3));
      end
    end
  endtask

  task automatic test_frame_div();
    int sway_tab [6] = '{1, 1, 2, 2, 2, 3};
    apply_reset();
    for (int f = 0; f < 6; f++) begin
      drive_frame(1'b0, $urandom_range(1, 3), $urandom_range(1, 3));
      checks += 3;
      if (tick_cnt[1] != 1) begin
        failures++;
        $display("FAIL div_tick frame=%0d got=%0d want=1", f, tick_cnt[1]);
      end
      if (obs_sway[1] !== 6'(sway_tab[f])) begin
        failures++;
        $display("FAIL div_sway frame=%0d got=%0d want=%0d", f, obs_sway[1], sway_tab[f]);
      end
      if (obs_scroll[1] !== 10'(f + 1)) begin
        failures++;
        $display("FAIL div_scroll frame=%0d got=%0d want=%0d", f, obs_scroll[1], f + 1);
      end
    end
  endtask

  task automatic test_pause_hold();
    int          sway_tab  [3] = '{4, 4, 3};
    sway_state_t state_tab [3] = '{HOLD_HI, FALL, FALL};
    apply_reset();
    for (int f = 0; f < 4; f++) drive_frame(1'b0, 1, 2);
    for (int f = 0; f < 4; f++) begin
      drive_frame(1'b1, $urandom_range(1, 3), $urandom_range(1, 3));
      checks += 4;
      if (tick_cnt[2] != 1) begin
        failures++;
        $display("FAIL pause_tick frame=%0d got=%0d want=1", f, tick_cnt[2]);
      end
      if (obs_sway[2] !== 6'd4) begin
        failures++;
        $display("FAIL pause_sway frame=%0d got=%0d want=4", f, obs_sway[2]);
      end
      if (obs_state[2] !== HOLD_HI) begin
        failures++;
        $display("FAIL pause_state frame=%0d got=%0d want=%0d", f, obs_state[2], HOLD_HI);
      end
      if (obs_scroll[2] !== 10'd4) begin
        failures++;
        $display("FAIL pause_scroll frame=%0d got=%0d want=4", f, obs_scroll[2]);
      end
    end
    for (int f = 0; f < 3; f++) begin
      drive_frame(1'b0, 1, 2);
      checks += 2;
      if (obs_sway[2] !== 6'(sway_tab[f])) begin
        failures++;
        $display("FAIL unpause_sway frame=%0d got=%0d want=%0d", f, obs_sway[2], sway_tab[f]);
      end
      if (obs_state[2] !== state_tab[f]) begin
        failures++;
        $display("FAIL unpause_state frame=%0d got=%0d want=%0d", f, obs_state[2], state_tab[f]);
      end
    end
  endtask

  task automatic test_scroll_wrap();
    int bad_ticks;
    apply_reset();
    bad_ticks = 0;
    for (int f = 0; f < 1023; f++) begin
      drive_frame(1'b0, 1, 1);
      for (int i = 0; i < NI; i++) bad_ticks += (tick_cnt[i] != 1) ? 1 : 0;
    end
    checks += 3;
    if (bad_ticks != 0) begin
      failures++;
      $display("FAIL wrap_ticks got %0d bad frames want 0", bad_ticks);
    end
    if (obs_scroll[0] !== 10'd1023) begin
      failures++;
      $display("FAIL wrap_pre_scroll got=%0d want=1023", obs_scroll[0]);
    end
    if (obs_scroll[3] !== 10'(exp_scroll(3))) begin
      failures++;
      $display("FAIL wrap_pre_scroll3 got=%0d want=%0d", obs_scroll[3], exp_scroll(3));
    end
    drive_frame(1'b0, 2, 2);
    for (int i = 0; i < NI; i++) begin
      checks += 2;
      if (obs_scroll[i] !== 10'(exp_scroll(i))) begin
        failures++;
        $display("FAIL wrap_scroll inst=%0d got=%0d want=%0d", i, obs_scroll[i], exp_scroll(i));
      end
      if (obs_sway[i] !== 6'(exp_sway(i))) begin
        failures++;
        $display("FAIL wrap_sway inst=%0d got=%0d want=%0d", i, obs_sway[i], exp_sway(i));
      end
    end
  endtask

  task automatic test_reset_mid_fall();
    apply_reset();
    for (int f = 0; f < 6; f++) drive_frame(1'b0, 1, 2);
    checks += 2;
    if (obs_sway[0] !== 6'd3 || obs_state[0] !== FALL) begin
      failures++;
      $display("FAIL midfall_pre got sway=%0d state=%0d want sway=3 state=%0d",
               obs_sway[0], obs_state[0], FALL);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NI; i++) n_adv[i] = 0;
    if (obs_sway[0] !== 6'd1 || obs_state[0] !== RISE || obs_scroll[0] !== 10'd0) begin
      failures++;
      $display("FAIL midfall_reset got sway=%0d state=%0d scroll=%0d want 1/%0d/0",
               obs_sway[0], obs_state[0], obs_scroll[0], RISE);
    end
    @(negedge clk);
    drive_frame(1'b0, $urandom_range(1, 6), 2);
    checks += 2;
    if (tick_cnt[0] != 1) begin
      failures++;
      $display("FAIL midfall_tick got=%0d want=1", tick_cnt[0]);
    end
    if (obs_sway[0] !== 6'd2) begin
      failures++;
      $display("FAIL midfall_sway got=%0d want=2", obs_sway[0]);
    end
    // Divider restart: two frames, reset, then the third frame after reset is the step.
    drive_frame(1'b0, 1, 2);
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      drive_frame(1'b0, 1, 2);
      checks++;
      if (obs_sway[1] !== 6'((f == 2) ? 2 : 1)) begin
        failures++;
        $display("FAIL div_reset frame=%0d got=%0d want=%0d", f, obs_sway[1], (f == 2) ? 2 : 1);
      end
    end
  endtask

  task automatic test_random();
    bit p;
    apply_reset();
    for (int f = 0; f < 60; f++) begin
      p = ($urandom_range(0, 3) == 0);
      drive_frame(p, $urandom_range(1, 12), $urandom_range(1, 4));
      for (int i = 0; i < NI; i++) begin
        checks += 5;
        if (tick_cnt[i] != 1 || !tick_first[i]) begin
          failures++;
          $display("FAIL rnd_tick frame=%0d inst=%0d got cnt=%0d first=%0d want 1/1",
                   f, i, tick_cnt[i], tick_first[i]);
        end
        if (obs_scroll[i] !== 10'(exp_scroll(i))) begin
          failures++;
          $display("FAIL rnd_scroll frame=%0d inst=%0d got=%0d want=%0d",
                   f, i, obs_scroll[i], exp_scroll(i));
        end
        if (obs_sway[i] !== 6'(exp_sway(i))) begin
          failures++;
          $display("FAIL rnd_sway frame=%0d inst=%0d got=%0d want=%0d",
                   f, i, obs_sway[i], exp_sway(i));
        end
        if (obs_dir[i] !== exp_dir(i)) begin
          failures++;
          $display("FAIL rnd_dir frame=%0d inst=%0d got=%b want=%b", f, i, obs_dir[i], exp_dir(i));
        end
        if (obs_state[i] !== exp_state(i)) begin
          failures++;
          $display("FAIL rnd_state frame=%0d inst=%0d got=%0d want=%0d",
                   f, i, obs_state[i], exp_state(i));
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    vsync    = 1'b0;
    pause    = 1'b0;
    for (int i = 0; i < NI; i++) n_adv[i] = 0;
    @(negedge clk);
    test_reset();
    test_sway_sequence();
    test_frame_div();
    test_pause_hold();
    test_scroll_wrap();
    test_reset_mid_fall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
